// File: rtl/serial_subtractor_5_bit_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_5_bit_pkg;

    localparam int DEFAULT_WIDTH = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_5_bit_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit position must borrow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_5_bit.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first, with a
// start/busy/done handshake; diff/bout hold the last result until the next one completes.
module serial_subtractor_5_bit
    import serial_subtractor_5_bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] diff_sr;
    logic             brw;
    logic             bit_d;
    logic             bit_bout;
    logic             can_accept;
    logic             last_bit;

    full_subtractor u_full_subtractor (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .bin  (brw),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign can_accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_bit   = (state == ST_RUN) && (cnt == CNT_LAST);

    // NOTE: every register, including the shift registers, is cleared by the synchronous
    // reset so an aborted operation leaves no stale bits behind; state uses <= throughout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
            diff_sr <= '0;
            brw     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    sh_a    <= sh_a >> 1;
                    sh_b    <= sh_b >> 1;
                    diff_sr <= {bit_d, diff_sr[WIDTH-1:1]};
                    brw     <= bit_bout;
                    if (last_bit) begin
                        // Publish the completed word; cnt holds rather than wrapping.
                        diff  <= {bit_d, diff_sr[WIDTH-1:1]};
                        bout  <= bit_bout;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (can_accept) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= ST_RUN;
                    end else begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_5_bit.sv
// Self-checking bench for serial_subtractor_5_bit: directed scenarios, exhaustive and random
// operands, all checked against plain-arithmetic expectations.
module tb_serial_subtractor_5_bit;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_subtractor_5_bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: unsigned arithmetic on the whole word.
    function automatic logic [W-1:0] model_diff(input int av, input int bv, input int bi);
        int r;
        r = av - bv - bi;
        return W'(r);
    endfunction

    function automatic logic model_bout(input int av, input int bv, input int bi);
        return av < (bv + bi);
    endfunction

    // Issue one op with a single-cycle start, checking handshake timing, result hold, result.
    task automatic run_op(input string tag, input int av, input int bv, input int bi);
        logic [W-1:0] prev_diff;
        logic         prev_bout;
        prev_diff = diff;
        prev_bout = bout;
        a     = W'(av);
        b     = W'(bv);
        bin   = 1'(bi);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = ~a;
        b     = ~b;
        for (int k = 1; k <= W; k++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done early"}, 32'(done), 32'd0);
            check({tag, " diff hold"}, 32'(diff), 32'(prev_diff));
            check({tag, " bout hold"}, 32'(bout), 32'(prev_bout));
            @(negedge clk);
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy end"}, 32'(busy), 32'd0);
        check({tag, " diff"}, 32'(diff), 32'(model_diff(av, bv, bi)));
        check({tag, " bout"}, 32'(bout), 32'(model_bout(av, bv, bi)));
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " diff stable"}, 32'(diff), 32'(model_diff(av, bv, bi)));
    endtask

    initial begin
        int dones;
        int gap;
        int ra;
        int rb;
        int rbi;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operand cases, including borrow and all-ones boundaries.
        run_op("t1 13-6", 13, 6, 0);
        run_op("t2 3-5", 3, 5, 0);
        run_op("t2 0-0-1", 0, 0, 1);
        run_op("t3 31-31", 31, 31, 0);
        run_op("t3 31-0-1", 31, 0, 1);

        // Start re-pulsed mid-RUN with other operands must be ignored.
        a = 5'd20; b = 5'd7; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                a = 5'd1; b = 5'd30; bin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) dones++;
            @(negedge clk);
        end
        check("t4 one done", 32'(dones), 32'd1);
        check("t4 diff", 32'(diff), 32'(model_diff(20, 7, 0)));
        check("t4 bout", 32'(bout), 32'(model_bout(20, 7, 0)));

        // Start held high: back-to-back ops complete every WIDTH+1 cycles.
        a = 5'd9; b = 5'd4; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 5'd4; b = 5'd9;
        gap = 0;
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("t5 first latency", 32'(gap), 32'(W));
        check("t5 first diff", 32'(diff), 32'(model_diff(9, 4, 0)));
        check("t5 first bout", 32'(bout), 32'(model_bout(9, 4, 0)));
        gap = 0;
        @(negedge clk);
        gap++;
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("t5 done period", 32'(gap), 32'(W + 1));
        check("t5 second diff", 32'(diff), 32'(model_diff(4, 9, 0)));
        check("t5 second bout", 32'(bout), 32'(model_bout(4, 9, 0)));
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during RUN aborts the op and clears outputs.
        a = 5'd17; b = 5'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 done", 32'(done), 32'd0);
        check("t6 diff", 32'(diff), 32'd0);
        check("t6 bout", 32'(bout), 32'd0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        check("t6 no activity", 32'(dones), 32'd0);
        run_op("t6 recover", 17, 2, 0);

        // Exhaustive operand/borrow space.
        for (int ia = 0; ia < (1 << W); ia++)
            for (int ib = 0; ib < (1 << W); ib++)
                for (int ic = 0; ic < 2; ic++)
                    run_op("exh", ia, ib, ic);

        // Random operands.
        for (int n = 0; n < 64; n++) begin
            ra  = int'($urandom_range((1 << W) - 1, 0));
            rb  = int'($urandom_range((1 << W) - 1, 0));
            rbi = int'($urandom_range(1, 0));
            run_op("rand", ra, rb, rbi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
